// File: rtl/mem_line_ctr.sv
// Line-oriented memory controller: accepts READ_LINE/WRITE_LINE over the C2/D2 buses,
// models a fixed access latency and returns beats MSB-byte-first.
module mem_line_ctr #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned LATENCY    = 100
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] A2,
    input  logic [1:0]        c2_in,
    input  logic [DATA_W-1:0] d2_in,
    output logic [1:0]        c2_out,
    output logic              c2_oe,
    output logic [DATA_W-1:0] d2_out,
    output logic              d2_oe,
    output logic              busy
);

    localparam int unsigned BEATS  = LINE_BYTES * 8 / DATA_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
    localparam int unsigned LINES  = 2 ** ADDR_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(LATENCY);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RESP = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_WR   = 2'b11;

    // Ascending beat index keeps beat 0 (lowest-addressed bytes) in the MSBs.
    typedef logic [0:BEATS-1][DATA_W-1:0] line_t;

    typedef enum logic [2:0] {
        StIdle,
        StWrBeats,
        StWrWait,
        StWrAck,
        StRdWait,
        StRdBeats,
        StTurn
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    line_t             line_q, line_d;

    line_t             mem_q [LINES];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    line_t             mem_wdata;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = line_q;
        c2_out    = CMD_NOP;
        c2_oe     = 1'b0;
        d2_out    = '0;
        d2_oe     = 1'b0;
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (c2_in == CMD_RD) begin
                    addr_d  = A2;
                    cnt_d   = LAT_LOAD;
                    state_d = StRdWait;
                end else if (c2_in == CMD_WR) begin
                    addr_d    = A2;
                    line_d[0] = d2_in;
                    if (BEATS == 1) begin
                        // Single-beat line commits on the command edge itself.
                        mem_we    = RESET;
                        mem_addr  = A2;
                        mem_wdata = line_d;
                        beat_d    = '0;
                        cnt_d     = LAT_LOAD;
                        state_d   = StWrWait;
                    end else begin
                        beat_d  = BEAT_W'(1);
                        state_d = StWrBeats;
                    end
                end
            end
            StWrBeats: begin
                line_d[beat_q] = d2_in;
                if (beat_q == LAST_BEAT) begin
                    mem_we    = RESET;
                    mem_wdata = line_d;
                    beat_d    = '0;
                    cnt_d     = LAT_LOAD;
                    state_d   = StWrWait;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            StWrWait: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StWrAck;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWrAck: begin
                c2_oe   = 1'b1;
                state_d = StTurn;
            end
            StRdWait: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    line_d  = mem_q[addr_q];
                    beat_d  = '0;
                    state_d = StRdBeats;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRdBeats: begin
                c2_out = CMD_RESP;
                c2_oe  = 1'b1;
                d2_oe  = 1'b1;
                d2_out = line_q[beat_q];
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = StTurn;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    // Array is deliberately outside the reset domain so contents survive RESET.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_line_ctr.sv
// Scoreboard bench for mem_line_ctr: default instance (16-bit, latency 100) plus a
// 32-bit latency-1 instance.
module tb_mem_line_ctr;

    typedef struct {
        int          cyc;
        logic [1:0]  c2;
        logic        doe;
        logic [31:0] d;
    } exp_t;

    typedef logic [15:0] l16_t [8];

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [9:0]  A2 = '0;
    logic [1:0]  c2_in = 2'b00;
    logic [15:0] d2_in = '0;
    logic [1:0]  c2_out;
    logic        c2_oe;
    logic [15:0] d2_out;
    logic        d2_oe;
    logic        busy;

    logic [9:0]  a32 = '0;
    logic [1:0]  c32_in = 2'b00;
    logic [31:0] d32_in = '0;
    logic [1:0]  c32_out;
    logic        c32_oe;
    logic [31:0] d32_out;
    logic        d32_oe;
    logic        busy32;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t q0[$];
    exp_t q1[$];

    mem_line_ctr dut (
        .clk    (clk),
        .RESET  (RESET),
        .A2     (A2),
        .c2_in  (c2_in),
        .d2_in  (d2_in),
        .c2_out (c2_out),
        .c2_oe  (c2_oe),
        .d2_out (d2_out),
        .d2_oe  (d2_oe),
        .busy   (busy)
    );

    mem_line_ctr #(
        .DATA_W  (32),
        .LATENCY (1)
    ) dut32 (
        .clk    (clk),
        .RESET  (RESET),
        .A2     (a32),
        .c2_in  (c32_in),
        .d2_in  (d32_in),
        .c2_out (c32_out),
        .c2_oe  (c32_oe),
        .d2_out (d32_out),
        .d2_oe  (d32_oe),
        .busy   (busy32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else passes++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (c2_oe) begin
            if (q0.size() == 0) begin
                chk("unexpected_c2_oe", 64'(c2_out), 64'hdead);
            end else begin
                e = q0.pop_front();
                chk("bus_cycle", 64'(cyc), 64'(e.cyc));
                chk("c2_out", 64'(c2_out), 64'(e.c2));
                chk("d2_oe", 64'(d2_oe), 64'(e.doe));
                chk("d2_out", 64'(d2_out), 64'(e.d));
            end
        end else begin
            chk("idle_bus", {45'd0, d2_oe, c2_out, d2_out}, 64'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (c32_oe) begin
            if (q1.size() == 0) begin
                chk("unexpected_c32_oe", 64'(c32_out), 64'hdead);
            end else begin
                e = q1.pop_front();
                chk("bus32_cycle", 64'(cyc), 64'(e.cyc));
                chk("c32_out", 64'(c32_out), 64'(e.c2));
                chk("d32_oe", 64'(d32_oe), 64'(e.doe));
                chk("d32_out", 64'(d32_out), 64'(e.d));
            end
        end else begin
            chk("idle_bus32", {29'd0, d32_oe, c32_out, d32_out}, 64'd0);
        end
    end

    task automatic wait_idle(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        chk("idle_timeout", 64'(busy), 64'd0);
        t = cyc;
    endtask

    task automatic wait_idle32(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy32 && n < 50);
        chk("idle32_timeout", 64'(busy32), 64'd0);
        t = cyc;
    endtask

    task automatic write16(input logic [9:0] addr, input l16_t d, input bit ack, output int t);
        @(negedge clk);
        A2 = addr;
        c2_in = 2'b11;
        d2_in = d[0];
        t = cyc + 1;
        if (ack) q0.push_back('{t + 107, 2'b00, 1'b0, 32'd0});
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            c2_in = 2'b00;
            d2_in = d[i];
        end
        @(negedge clk);
        d2_in = '0;
    endtask

    task automatic read16(input logic [9:0] addr, input l16_t d, input int nb, output int t);
        @(negedge clk);
        A2 = addr;
        c2_in = 2'b10;
        t = cyc + 1;
        for (int i = 0; i < nb; i++) q0.push_back('{t + 100 + i, 2'b01, 1'b1, 32'(d[i])});
        @(negedge clk);
        c2_in = 2'b00;
    endtask

    initial begin
        l16_t pa, p3, p9, pf;
        logic [31:0] w32 [4];
        int t, ti;

        for (int i = 0; i < 8; i++) begin
            pa[i] = {8'(2 * i + 1), 8'(2 * i + 2)};
            p3[i] = 16'h3300 + 16'(i);
            p9[i] = 16'h9000 + 16'(i * 17);
            pf[i] = 16'hFFFF;
        end
        for (int i = 0; i < 4; i++) begin
            w32[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
        end

        // Asynchronous reset values, checked before any clock edge
        #2 RESET = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_oe", {62'd0, c2_oe, d2_oe}, 64'd0);
        chk("rst_out", {46'd0, c2_out, d2_out}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        RESET = 1'b1;

        // Write then read back line 5 with the canonical beat pattern
        write16(10'd5, pa, 1'b1, t);
        wait_idle(ti);
        chk("wr_turnaround", 64'(ti), 64'(t + 109));
        read16(10'd5, pa, 8, t);
        wait_idle(ti);
        chk("rd_turnaround", 64'(ti), 64'(t + 109));

        // Commands while busy are ignored
        write16(10'd3, p3, 1'b1, t);
        wait_idle(ti);
        read16(10'd3, p3, 8, t);
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            A2 = 10'd3;
            c2_in = (i % 2 == 1) ? 2'b11 : 2'b00;
            d2_in = 16'hA5A5;
            chk("busy_hold", 64'(busy), 64'd1);
        end
        c2_in = 2'b00;
        d2_in = '0;
        wait_idle(ti);
        chk("rd3_turnaround", 64'(ti), 64'(t + 109));
        read16(10'd3, p3, 8, t);
        wait_idle(ti);

        // Write interrupted by reset at beat 4 leaves line 9 unchanged
        write16(10'd9, p9, 1'b1, t);
        wait_idle(ti);
        @(negedge clk);
        A2 = 10'd9;
        c2_in = 2'b11;
        d2_in = 16'hFFFF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            c2_in = 2'b00;
            d2_in = pf[i];
        end
        #1 RESET = 1'b0;
        #1;
        chk("wr_rst_oe", {62'd0, c2_oe, d2_oe}, 64'd0);
        chk("wr_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        RESET = 1'b1;
        d2_in = '0;
        read16(10'd9, p9, 8, t);
        wait_idle(ti);

        // Reset during read beat 2, then a full read afterwards
        read16(10'd5, pa, 3, t);
        while (cyc < t + 102) @(negedge clk);
        #1 RESET = 1'b0;
        #1;
        chk("rd_rst_oe", {62'd0, c2_oe, d2_oe}, 64'd0);
        chk("rd_rst_out", {46'd0, c2_out, d2_out}, 64'd0);
        @(negedge clk);
        RESET = 1'b1;
        read16(10'd5, pa, 8, t);
        wait_idle(ti);
        chk("rd_after_rst", 64'(ti), 64'(t + 109));

        // 32-bit data, latency 1
        @(negedge clk);
        a32 = 10'd0;
        c32_in = 2'b11;
        d32_in = w32[0];
        t = cyc + 1;
        q1.push_back('{t + 4, 2'b00, 1'b0, 32'd0});
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            c32_in = 2'b00;
            d32_in = w32[i];
        end
        @(negedge clk);
        d32_in = '0;
        wait_idle32(ti);
        chk("wr32_turnaround", 64'(ti), 64'(t + 6));
        @(negedge clk);
        c32_in = 2'b10;
        t = cyc + 1;
        for (int i = 0; i < 4; i++) q1.push_back('{t + 1 + i, 2'b01, 1'b1, w32[i]});
        @(negedge clk);
        c32_in = 2'b00;
        wait_idle32(ti);
        chk("rd32_turnaround", 64'(ti), 64'(t + 6));

        repeat (3) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
